// File: rtl/mmio_gpio_timer_if.sv
// Word-addressed MMIO bus between the CPU data-bus decode and the GPIO/timer block.
interface mmio_gpio_timer_if #(
    parameter int ADDR_WIDTH = 26
);
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [31:0]           i_data;
    logic [3:0]            i_byte_we;
    logic                  i_read_en;
    logic [31:0]           o_data;

    modport master (
        output i_addr,
        output i_data,
        output i_byte_we,
        output i_read_en,
        input  o_data
    );

    modport slave (
        input  i_addr,
        input  i_data,
        input  i_byte_we,
        input  i_read_en,
        output o_data
    );
endinterface

// File: rtl/mmio_gpio_timer.sv
// GPIO with per-pin output enable and sticky rising-edge flags, a prescaled
// 32-bit tick counter, and NUM_CMP compare channels (one-shot or periodic).
// All event flags are combined into one level interrupt.
module mmio_gpio_timer #(
    parameter int ADDR_WIDTH = 26,
    parameter int GPIO_WIDTH = 32,
    parameter int NUM_CMP    = 2,
    parameter int CLK_FREQ   = 25000000,
    parameter int TICK_HZ    = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mmio_gpio_timer_if.slave      bus,
    output logic [GPIO_WIDTH-1:0] o_gpio_out,
    output logic [GPIO_WIDTH-1:0] o_gpio_oe,
    input  logic [GPIO_WIDTH-1:0] i_gpio_in,
    output logic                  o_irq
);

    localparam int CLKS_PER_TICK = CLK_FREQ / TICK_HZ;
    localparam int PRE_W         = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_TICK - 1);

    localparam logic [ADDR_WIDTH-1:0] A_GPIO_OUT = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_GPIO_IN  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_GPIO_OE  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_RISE     = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_RISE_IE  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_TICK     = ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH-1:0] A_CMP_STAT = ADDR_WIDTH'(6);
    localparam logic [ADDR_WIDTH-1:0] A_CMP_IE   = ADDR_WIDTH'(7);

    // Parameter legality is checked at elaboration so a bad build never links.
    generate
        if (CLKS_PER_TICK < 1) begin : g_bad_tick
            $error("mmio_gpio_timer: CLK_FREQ/TICK_HZ must be >= 1");
        end
        if (GPIO_WIDTH < 1 || GPIO_WIDTH > 32) begin : g_bad_gpio
            $error("mmio_gpio_timer: GPIO_WIDTH must be 1..32");
        end
        if (NUM_CMP < 1 || NUM_CMP > 8) begin : g_bad_cmp
            $error("mmio_gpio_timer: NUM_CMP must be 1..8");
        end
    endgenerate

    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    logic [GPIO_WIDTH-1:0] r_gpio_out, r_gpio_oe, r_rise, r_rise_ie;
    logic [GPIO_WIDTH-1:0] r_s1, r_s2, r_s3;
    logic [PRE_W-1:0]      r_pre;
    logic [31:0]           r_tick;
    logic [NUM_CMP-1:0]    r_cmp_stat, r_cmp_ie, r_cmp_en, r_cmp_prd;
    logic [31:0]           r_cmp_val [NUM_CMP];
    logic [31:0]           r_cmp_per [NUM_CMP];
    logic [31:0]           r_rdata;

    logic [31:0]        w_mask, w_clr, w_rd, w_tick_nxt;
    logic               w_wr, w_tick_inc;
    logic [NUM_CMP-1:0] w_sel_val, w_sel_per, w_sel_ctl, w_match;

    assign w_wr       = |bus.i_byte_we;
    assign w_mask     = {{8{bus.i_byte_we[3]}}, {8{bus.i_byte_we[2]}},
                         {8{bus.i_byte_we[1]}}, {8{bus.i_byte_we[0]}}};
    assign w_clr      = bus.i_data & w_mask;
    assign w_tick_inc = (r_pre == PRE_LAST);
    assign w_tick_nxt = r_tick + 32'd1;

    // Per-channel address decode; word 11+4k of each channel group is a hole.
    always_comb begin
        w_sel_val = '0;
        w_sel_per = '0;
        w_sel_ctl = '0;
        for (int k = 0; k < NUM_CMP; k++) begin
            w_sel_val[k] = (bus.i_addr == ADDR_WIDTH'(8 + 4 * k));
            w_sel_per[k] = (bus.i_addr == ADDR_WIDTH'(9 + 4 * k));
            w_sel_ctl[k] = (bus.i_addr == ADDR_WIDTH'(10 + 4 * k));
        end
    end

    // A channel matches on the tick edge when its value equals the new tick.
    always_comb begin
        w_match = '0;
        for (int k = 0; k < NUM_CMP; k++) begin
            w_match[k] = w_tick_inc && r_cmp_en[k] && (r_cmp_val[k] == w_tick_nxt);
        end
    end

    // Read multiplexer over the current (pre-write) register contents.
    always_comb begin
        w_rd = 32'd0;
        case (bus.i_addr)
            A_GPIO_OUT: w_rd = 32'(r_gpio_out);
            A_GPIO_IN:  w_rd = 32'(r_s2);
            A_GPIO_OE:  w_rd = 32'(r_gpio_oe);
            A_RISE:     w_rd = 32'(r_rise);
            A_RISE_IE:  w_rd = 32'(r_rise_ie);
            A_TICK:     w_rd = r_tick;
            A_CMP_STAT: w_rd = 32'(r_cmp_stat);
            A_CMP_IE:   w_rd = 32'(r_cmp_ie);
            default:    w_rd = 32'd0;
        endcase
        for (int k = 0; k < NUM_CMP; k++) begin
            if (w_sel_val[k]) w_rd = r_cmp_val[k];
            if (w_sel_per[k]) w_rd = r_cmp_per[k];
            if (w_sel_ctl[k]) w_rd = {30'd0, r_cmp_prd[k], r_cmp_en[k]};
        end
    end

    // Registered read port: addressed value on a strobe, zero otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_rdata <= 32'd0;
        else       r_rdata <= bus.i_read_en ? w_rd : 32'd0;
    end

    // GPIO software-owned registers with byte-lane writes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gpio_out <= '0;
            r_gpio_oe  <= '0;
            r_rise_ie  <= '0;
        end else if (w_wr) begin
            if (bus.i_addr == A_GPIO_OUT)
                r_gpio_out <= GPIO_WIDTH'(f_merge(32'(r_gpio_out), bus.i_data, w_mask));
            if (bus.i_addr == A_GPIO_OE)
                r_gpio_oe <= GPIO_WIDTH'(f_merge(32'(r_gpio_oe), bus.i_data, w_mask));
            if (bus.i_addr == A_RISE_IE)
                r_rise_ie <= GPIO_WIDTH'(f_merge(32'(r_rise_ie), bus.i_data, w_mask));
        end
    end

    // Two-flop input synchroniser, a third stage for edge detect, sticky rise flags.
    // The hardware set is OR-ed after the clear so a fresh edge wins over W1C.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s3   <= '0;
            r_rise <= '0;
        end else begin
            r_s1   <= i_gpio_in;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_rise <= (r_rise & ~((w_wr && bus.i_addr == A_RISE) ? GPIO_WIDTH'(w_clr) : '0))
                      | (r_s2 & ~r_s3);
        end
    end

    // Prescaler wraps every CLKS_PER_TICK cycles and advances the tick counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pre  <= '0;
            r_tick <= 32'd0;
        end else if (w_tick_inc) begin
            r_pre  <= '0;
            r_tick <= w_tick_nxt;
        end else begin
            r_pre  <= r_pre + PRE_W'(1);
        end
    end

    // Compare status (match wins over W1C) and interrupt enables.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cmp_stat <= '0;
            r_cmp_ie   <= '0;
        end else begin
            r_cmp_stat <= (r_cmp_stat & ~((w_wr && bus.i_addr == A_CMP_STAT) ? NUM_CMP'(w_clr) : '0))
                          | w_match;
            if (w_wr && bus.i_addr == A_CMP_IE)
                r_cmp_ie <= NUM_CMP'(f_merge(32'(r_cmp_ie), bus.i_data, w_mask));
        end
    end

    // Channel state: a software write in the match cycle overrides the reload/disable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_CMP; k++) begin
                r_cmp_val[k] <= 32'd0;
                r_cmp_per[k] <= 32'd0;
            end
            r_cmp_en  <= '0;
            r_cmp_prd <= '0;
        end else begin
            for (int k = 0; k < NUM_CMP; k++) begin
                if (w_wr && w_sel_val[k])
                    r_cmp_val[k] <= f_merge(r_cmp_val[k], bus.i_data, w_mask);
                else if (w_match[k] && r_cmp_prd[k])
                    r_cmp_val[k] <= r_cmp_val[k] + r_cmp_per[k];

                if (w_wr && w_sel_per[k])
                    r_cmp_per[k] <= f_merge(r_cmp_per[k], bus.i_data, w_mask);

                if (w_wr && w_sel_ctl[k] && bus.i_byte_we[0]) begin
                    r_cmp_en[k]  <= bus.i_data[0];
                    r_cmp_prd[k] <= bus.i_data[1];
                end else if (w_match[k] && !r_cmp_prd[k]) begin
                    r_cmp_en[k]  <= 1'b0;
                end
            end
        end
    end

    assign bus.o_data = r_rdata;
    assign o_gpio_out = r_gpio_out;
    assign o_gpio_oe  = r_gpio_oe;
    assign o_irq      = (|(r_rise & r_rise_ie)) | (|(r_cmp_stat & r_cmp_ie));

endmodule
